// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame scheduler: FSM states, slave
// command codes and frame field layout.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_STAGED = 2'd1,
    ST_SENT   = 2'd2
  } state_t;

  localparam int CMD_W = 2;
  localparam logic [CMD_W-1:0] CMD_NONE     = 2'b00;
  localparam logic [CMD_W-1:0] CMD_SET_HOLD = 2'b01;
  localparam logic [CMD_W-1:0] CMD_CLR_HOLD = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RST_PTR  = 2'b11;

  // Frame layout: {valid, ch_id, payload}, payload at the LSB end.
  localparam int CH_ID_W     = 2;
  localparam int PAYLOAD_OFS = 0;

  function automatic int ch_id_ofs(input int data_bits);
    return PAYLOAD_OFS + data_bits;
  endfunction

  function automatic int valid_ofs(input int data_bits);
    return PAYLOAD_OFS + data_bits + CH_ID_W;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one position past
// ptr and wraps, returning a one-hot grant plus the winning index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  // Scan requesters in rotated order and keep the first hit.
  always_comb begin
    int  c;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      c = (int'(ptr) + 1 + i) % N_REQ;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/spi_frame_sched.sv
// Schedules requester words into SPI slave frames: round-robin staging,
// ack on capture, and a hold mode that re-sends the last committed word.
module spi_frame_sched
  import spi_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_BITS    = 13,
  parameter int TX_BUFF_BITS = 16,
  parameter int RX_BUFF_BITS = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*DATA_BITS-1:0] i_data,
  output logic [N_REQ-1:0]           o_ack,
  output logic [TX_BUFF_BITS-1:0]    o_TX_buff,
  input  logic                       i_data_capt_st,
  input  logic                       i_ssel_n,
  input  logic [RX_BUFF_BITS-1:0]    i_RX_buff,
  output logic                       o_busy,
  output logic                       o_hold
);

  localparam int IDX_W     = 2;
  localparam int CH_OFS    = ch_id_ofs(DATA_BITS);
  localparam int VALID_BIT = valid_ofs(DATA_BITS);

  state_t                   state;
  logic                     ssel_meta, ssel_s, ssel_d, capt_d;
  logic                     cap_evt, end_evt;
  logic [IDX_W-1:0]         rr_ptr, owner, gnt_idx;
  logic [N_REQ-1:0]         gnt_oh;
  logic                     gnt_vld, resend, next_hold;
  logic [CMD_W-1:0]         cmd;
  logic [DATA_BITS-1:0]     payload;
  logic [TX_BUFF_BITS-1:0]  frame_next;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (i_req),
    .ptr   (rr_ptr),
    .grant (gnt_oh),
    .idx   (gnt_idx)
  );

  assign gnt_vld = |gnt_oh;
  assign payload = i_data[int'(gnt_idx)*DATA_BITS +: DATA_BITS];
  assign cap_evt = i_data_capt_st & ~capt_d;
  assign end_evt = ssel_s & ~ssel_d;
  assign cmd     = i_RX_buff[CMD_W-1:0];

  // Assemble the frame word for the current arbitration winner.
  always_comb begin
    frame_next                          = '0;
    frame_next[VALID_BIT]               = 1'b1;
    frame_next[CH_OFS +: CH_ID_W]       = gnt_idx;
    frame_next[PAYLOAD_OFS +: DATA_BITS] = payload;
  end

  // Hold state after the command received with the finishing frame.
  always_comb begin
    case (cmd)
      CMD_SET_HOLD: next_hold = 1'b1;
      CMD_CLR_HOLD: next_hold = 1'b0;
      CMD_RST_PTR:  next_hold = 1'b0;
      default:      next_hold = o_hold;
    endcase
  end

  // Synchronisers, edge detectors and the frame FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // ssel_d is the third stage of the chip-select chain, so it idles high
      // like the synchroniser and no end_evt appears out of reset.
      ssel_meta <= 1'b1;
      ssel_s    <= 1'b1;
      ssel_d    <= 1'b1;
      capt_d    <= 1'b0;
      state     <= ST_EMPTY;
      o_TX_buff <= '0;
      o_ack     <= '0;
      o_busy    <= 1'b0;
      o_hold    <= 1'b0;
      rr_ptr    <= IDX_W'(N_REQ - 1);
      owner     <= '0;
      resend    <= 1'b0;
    end else begin
      ssel_meta <= i_ssel_n;
      ssel_s    <= ssel_meta;
      ssel_d    <= ssel_s;
      capt_d    <= i_data_capt_st;
      o_ack     <= '0;
      case (state)
        ST_EMPTY: begin
          if (cap_evt) begin
            o_TX_buff <= '0;
            resend    <= 1'b0;
            o_busy    <= 1'b1;
            state     <= ST_SENT;
          end else if (gnt_vld && ssel_s) begin
            o_TX_buff <= frame_next;
            owner     <= gnt_idx;
            resend    <= 1'b0;
            state     <= ST_STAGED;
          end else begin
            o_TX_buff <= '0;
          end
        end
        ST_STAGED: begin
          // A frame end coinciding with capture wins; the word is not committed.
          if (end_evt) begin
            resend <= 1'b0;
            state  <= ST_EMPTY;
          end else if (cap_evt) begin
            if (!resend) begin
              o_ack[owner] <= 1'b1;
              rr_ptr       <= owner;
            end else begin
              rr_ptr <= rr_ptr;
            end
            o_busy <= 1'b1;
            state  <= ST_SENT;
          end else begin
            state <= ST_STAGED;
          end
        end
        ST_SENT: begin
          if (end_evt) begin
            o_busy <= 1'b0;
            o_hold <= next_hold;
            if (cmd == CMD_RST_PTR) begin
              rr_ptr <= IDX_W'(N_REQ - 1);
            end else begin
              rr_ptr <= rr_ptr;
            end
            if (next_hold && o_TX_buff[VALID_BIT]) begin
              resend <= 1'b1;
              state  <= ST_STAGED;
            end else begin
              resend    <= 1'b0;
              o_TX_buff <= '0;
              state     <= ST_EMPTY;
            end
          end else begin
            state <= ST_SENT;
          end
        end
        default: begin
          o_TX_buff <= '0;
          o_busy    <= 1'b0;
          resend    <= 1'b0;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_sched.sv
// Directed bench for spi_frame_sched; expected frame words and acks are
// queued when a word is staged and retired when the frame completes.
module tb_spi_frame_sched;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_req;
  logic [51:0] i_data;
  logic [3:0]  o_ack;
  logic [15:0] o_TX_buff;
  logic        i_data_capt_st;
  logic        i_ssel_n;
  logic [1:0]  i_RX_buff;
  logic        o_busy;
  logic        o_hold;

  typedef struct packed {
    logic [15:0] tx;
    logic [3:0]  ack;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [12:0] pay [4];

  spi_frame_sched dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req          (i_req),
    .i_data         (i_data),
    .o_ack          (o_ack),
    .o_TX_buff      (o_TX_buff),
    .i_data_capt_st (i_data_capt_st),
    .i_ssel_n       (i_ssel_n),
    .i_RX_buff      (i_RX_buff),
    .o_busy         (o_busy),
    .o_hold         (o_hold)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fw(input logic [1:0] ch);
    return {1'b1, ch, pay[ch]};
  endfunction

  // Run one SPI frame: select low, capture, select high with a command.
  task automatic do_frame(input string tag, input logic [1:0] cmd);
    logic [15:0] tx_at_cap;
    logic [3:0]  ack_acc;
    int          ack_cnt;
    exp_t        e;
    ack_acc  = 4'b0000;
    ack_cnt  = 0;
    i_ssel_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (o_ack != 4'b0000) begin ack_cnt++; ack_acc |= o_ack; end
    end
    tx_at_cap      = o_TX_buff;
    i_data_capt_st = 1'b1;
    step();
    if (o_ack != 4'b0000) begin ack_cnt++; ack_acc |= o_ack; end
    check({tag, "_busy_set"}, 32'(o_busy), 32'd1);
    step();
    if (o_ack != 4'b0000) begin ack_cnt++; ack_acc |= o_ack; end
    i_data_capt_st = 1'b0;
    i_RX_buff      = cmd;
    i_ssel_n       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_ack != 4'b0000) begin ack_cnt++; ack_acc |= o_ack; end
      if (!o_busy) break;
    end
    check({tag, "_busy_clear"}, 32'(o_busy), 32'd0);
    i_RX_buff = 2'b00;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_sb_underflow: observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_tx"}, 32'(tx_at_cap), 32'(e.tx));
      check({tag, "_ack"}, 32'(ack_acc), 32'(e.ack));
      check({tag, "_ack_cnt"}, 32'(ack_cnt), (e.ack != 4'b0000) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    pay   = '{13'h0101, 13'h0A52, 13'h0ABC, 13'h1F37};
    i_data = {pay[3], pay[2], pay[1], pay[0]};
    i_rst = 1'b1; i_req = 4'b0000; i_data_capt_st = 1'b0;
    i_ssel_n = 1'b1; i_RX_buff = 2'b00;
    step(); step();
    check("rst_tx", 32'(o_TX_buff), 32'h0);
    check("rst_ack", 32'(o_ack), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_hold", 32'(o_hold), 32'h0);
    i_rst = 1'b0;
    step(); step(); step();

    // Single requester, word dropped while staged must still be acked.
    i_req = 4'b0100;
    step();
    check("r2_latency", 32'(o_TX_buff), 32'hCABC);
    sb_q.push_back('{tx: 16'hCABC, ack: 4'b0100});
    i_req = 4'b0000;
    do_frame("r2", 2'b00);

    // Idle frame; its command puts the pointer back to N_REQ-1.
    sb_q.push_back('{tx: 16'h0000, ack: 4'b0000});
    do_frame("idle", 2'b11);

    // All four requesting: rotation 0,1,2,3,0.
    i_req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      step();
      check("rr_stage", 32'(o_TX_buff), 32'(fw(order[f])));
      sb_q.push_back('{tx: fw(order[f]), ack: 4'b0001 << order[f]});
      do_frame("rr", 2'b00);
    end
    i_req = 4'b0000;

    // Hold: channel 1 committed, then re-sent three times without ack.
    step();
    i_req = 4'b0010;
    step();
    check("hold_stage", 32'(o_TX_buff), 32'(fw(2'd1)));
    sb_q.push_back('{tx: fw(2'd1), ack: 4'b0010});
    i_req = 4'b1000;
    do_frame("hold_set", 2'b01);
    check("hold_on", 32'(o_hold), 32'd1);
    for (int f = 0; f < 3; f++) begin
      check("hold_tx_kept", 32'(o_TX_buff), 32'(fw(2'd1)));
      sb_q.push_back('{tx: fw(2'd1), ack: 4'b0000});
      do_frame("hold_resend", (f == 2) ? 2'b10 : 2'b00);
    end
    check("hold_off", 32'(o_hold), 32'd0);
    step();
    check("hold_resume", 32'(o_TX_buff), 32'(fw(2'd3)));
    sb_q.push_back('{tx: fw(2'd3), ack: 4'b1000});
    i_req = 4'b0000;
    do_frame("resume", 2'b00);

    // Reset while staged discards the word; requester is re-granted.
    i_req = 4'b0001;
    step();
    check("rst_mid_stage", 32'(o_TX_buff), 32'(fw(2'd0)));
    i_rst = 1'b1;
    step();
    check("rst_mid_tx", 32'(o_TX_buff), 32'h0);
    check("rst_mid_ack", 32'(o_ack), 32'h0);
    check("rst_mid_busy", 32'(o_busy), 32'h0);
    check("rst_mid_hold", 32'(o_hold), 32'h0);
    i_rst = 1'b0;
    step();
    check("rst_regrant", 32'(o_TX_buff), 32'(fw(2'd0)));
    check("rst_regrant_ack", 32'(o_ack), 32'h0);
    sb_q.push_back('{tx: fw(2'd0), ack: 4'b0001});
    i_req = 4'b0000;
    do_frame("after_rst", 2'b00);

    // Frame end and capture in the same cycle while staged.
    i_req = 4'b0010;
    step();
    check("coinc_stage", 32'(o_TX_buff), 32'(fw(2'd1)));
    i_req = 4'b0000;
    i_ssel_n = 1'b0;
    step(); step(); step(); step();
    i_ssel_n = 1'b1;
    step(); step();
    i_data_capt_st = 1'b1;
    step();
    check("coinc_ack", 32'(o_ack), 32'h0);
    check("coinc_busy", 32'(o_busy), 32'h0);
    step();
    check("coinc_ack2", 32'(o_ack), 32'h0);
    check("coinc_empty_tx", 32'(o_TX_buff), 32'h0);
    i_data_capt_st = 1'b0;
    step();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
